// File: rtl/gate_unit_arbiter.sv
// Arbitrates N requesters onto one registered AND/OR/NOT unit and returns {a&b, a|b, ~a} with the owner's index.
// Optional macro GATE_ARB_RR_EN selects round-robin arbitration; otherwise fixed priority (lowest index wins).
module gate_unit_arbiter #(
   parameter int N   = 4,
   parameter int W   = 1,
   parameter int IDW = $clog2(N)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [N-1:0]   req,
   input  logic [N*W-1:0] op_a,
   input  logic [N*W-1:0] op_b,
   output logic [N-1:0]   gnt,
   output logic           rsp_valid,
   input  logic           rsp_ready,
   output logic [IDW-1:0] rsp_id,
   output logic [3*W-1:0] rsp_y,
   output logic           busy
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t         state_reg, state_next;
   logic [N-1:0]   gnt_reg;
   logic [W-1:0]   a_reg, b_reg;
   logic [IDW-1:0] id_reg;
   logic           rsp_valid_reg;
   logic [IDW-1:0] rsp_id_reg;
   logic [3*W-1:0] rsp_y_reg;

   logic [IDW-1:0] win_idx;
   logic           win_found;
   logic [N-1:0]   win_onehot;

   logic [W-1:0]   a_slice [N];
   logic [W-1:0]   b_slice [N];

   for (genvar gi = 0; gi < N; gi++) begin : g_slice
      assign a_slice[gi] = op_a[gi*W +: W];
      assign b_slice[gi] = op_b[gi*W +: W];
   end

`ifdef GATE_ARB_RR_EN
   logic [IDW-1:0] ptr_reg;
   int             rr_cand;

   // Search starts just after the last served index and wraps modulo N.
   always_comb begin
      win_idx   = '0;
      win_found = 1'b0;
      rr_cand   = 0;
      for (int k = 1; k <= N; k++) begin
         rr_cand = (int'(ptr_reg) + k) % N;
         if (!win_found && req[rr_cand]) begin
            win_found = 1'b1;
            win_idx   = IDW'(rr_cand);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_reg <= IDW'(N-1);
      end else if (state_reg == RESP && rsp_ready) begin
         ptr_reg <= rsp_id_reg;
      end
   end
`else
   always_comb begin
      win_idx   = '0;
      win_found = 1'b0;
      for (int i = N-1; i >= 0; i--) begin
         if (req[i]) begin
            win_found = 1'b1;
            win_idx   = IDW'(i);
         end
      end
   end
`endif

   assign win_onehot = {{(N-1){1'b0}}, 1'b1} << win_idx;

   always_comb begin
      state_next = state_reg;
      busy       = (state_reg != IDLE);
      case (state_reg)
         IDLE:    if (win_found) state_next = EXEC;
         EXEC:    state_next = RESP;
         RESP:    if (rsp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         gnt_reg       <= '0;
         a_reg         <= '0;
         b_reg         <= '0;
         id_reg        <= '0;
         rsp_valid_reg <= 1'b0;
         rsp_id_reg    <= '0;
         rsp_y_reg     <= '0;
      end else begin
         state_reg <= state_next;
         gnt_reg   <= '0;
         // Operands are captured with the grant so the requester may change them afterwards.
         if (state_reg == IDLE && win_found) begin
            gnt_reg <= win_onehot;
            a_reg   <= a_slice[win_idx];
            b_reg   <= b_slice[win_idx];
            id_reg  <= win_idx;
         end
         if (state_reg == EXEC) begin
            rsp_y_reg     <= {a_reg & b_reg, a_reg | b_reg, ~a_reg};
            rsp_id_reg    <= id_reg;
            rsp_valid_reg <= 1'b1;
         end
         if (state_reg == RESP && rsp_ready) begin
            rsp_valid_reg <= 1'b0;
         end
      end
   end

   assign gnt       = gnt_reg;
   assign rsp_valid = rsp_valid_reg;
   assign rsp_id    = rsp_id_reg;
   assign rsp_y     = rsp_y_reg;
endmodule

// File: tb/tb_gate_unit_arbiter.sv
// Scoreboard bench for gate_unit_arbiter: a transaction-level model predicts grants and responses,
// a negedge monitor compares the DUT against it. Honours GATE_ARB_RR_EN like the design.
module tb_gate_unit_arbiter;
   localparam int N   = 4;
   localparam int W   = 1;
   localparam int IDW = $clog2(N);

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   req = '0;
   logic [N*W-1:0] op_a = '0;
   logic [N*W-1:0] op_b = '0;
   logic [N-1:0]   gnt;
   logic           rsp_valid;
   logic           rsp_ready = 1'b1;
   logic [IDW-1:0] rsp_id;
   logic [3*W-1:0] rsp_y;
   logic           busy;

   int checks   = 0;
   int failures = 0;

   gate_unit_arbiter #(.N(N), .W(W)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .op_a(op_a), .op_b(op_b),
      .gnt(gnt), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_y(rsp_y), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [3*W-1:0] gate_fn(input logic [W-1:0] a, input logic [W-1:0] b);
      return {a & b, a | b, ~a};
   endfunction

   // Reference model: one transaction in flight at a time; arbitration only while free.
   logic [IDW+3*W-1:0] sb[$];
   int             m_phase = 0;   // 0 free, 1 granted, 2 awaiting acceptance
   int             m_ptr   = N-1;
   int             m_cur   = 0;
   logic [N-1:0]   exp_gnt   = '0;
   logic           exp_busy  = 1'b0;
   logic           exp_valid = 1'b0;

   function automatic int pick(input logic [N-1:0] r, input int ptr);
`ifdef GATE_ARB_RR_EN
      for (int k = 1; k <= N; k++)
         if (r[(ptr + k) % N]) return (ptr + k) % N;
`else
      for (int i = 0; i < N; i++)
         if (r[i]) return i;
`endif
      return -1;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase = 0; m_ptr = N-1; exp_gnt = '0; exp_busy = 0; exp_valid = 0;
         sb.delete();
      end else begin
         if (m_phase == 0) begin
            if (req != 0) begin
               m_cur = pick(req, m_ptr);
               sb.push_back({IDW'(m_cur), gate_fn(op_a[m_cur*W +: W], op_b[m_cur*W +: W])});
               exp_gnt = '0; exp_gnt[m_cur] = 1'b1;
               exp_busy = 1; m_phase = 1;
            end
         end else if (m_phase == 1) begin
            exp_gnt = '0; exp_valid = 1; m_phase = 2;
         end else if (rsp_ready) begin
            exp_valid = 0; exp_busy = 0; m_phase = 0; m_ptr = m_cur;
         end
      end
   end

   always @(negedge clk) begin
      check("gnt", 32'(gnt), 32'(exp_gnt));
      check("busy", 32'(busy), 32'(exp_busy));
      check("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
      if (rsp_valid) begin
         if (sb.size() == 0) begin
            check("sb_nonempty", 0, 1);
         end else begin
            check("rsp_id", 32'(rsp_id), 32'(sb[0][IDW+3*W-1:3*W]));
            check("rsp_y", 32'(rsp_y), 32'(sb[0][3*W-1:0]));
            if (rsp_ready) void'(sb.pop_front());
         end
      end
   end

   task automatic outputs_zero(input string nm);
      check({nm, "_gnt"}, 32'(gnt), 0);
      check({nm, "_valid"}, 32'(rsp_valid), 0);
      check({nm, "_id"}, 32'(rsp_id), 0);
      check({nm, "_y"}, 32'(rsp_y), 0);
      check({nm, "_busy"}, 32'(busy), 0);
   endtask

   // Raise req, wait for the grant, optionally drop req in the grant cycle.
   task automatic grant_wait(input logic [N-1:0] r, input bit drop);
      bit seen = 0;
      @(posedge clk); #1; req = r;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(posedge clk); #1;
         if (gnt != 0) seen = 1;
      end
      if (!seen) check("grant_timeout", 0, 1);
      if (drop) req = '0;
   endtask

   task automatic wait_idle();
      bit idle = 0;
      for (int i = 0; i < 60 && !idle; i++) begin
         @(posedge clk); #1;
         if (!busy) idle = 1;
      end
      if (!idle) check("idle_timeout", 0, 1);
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 outputs_zero("reset");
      rst_n = 1'b1;

      // Truth table on requester 2.
      for (int ab = 0; ab < 4; ab++) begin
         op_a = '0; op_b = '0;
         op_a[2] = ab[1]; op_b[2] = ab[0];
         grant_wait(4'b0100, 1);
         check("tt_gnt", 32'(gnt), 32'h4);
         wait_idle();
      end

      // All four requesters held high.
      @(posedge clk); #1; req = 4'hF; op_a = 4'b1010; op_b = 4'b0110;
      repeat (15) @(posedge clk);
      #1 req = '0;
      wait_idle();

      // Back-pressure with a withdrawn request from requester 1 during the response.
      rsp_ready = 1'b0;
      grant_wait(4'b0001, 1);
      repeat (2) @(posedge clk);
      #1 req = 4'b0010;
      @(posedge clk); #1 req = '0;
      repeat (3) @(posedge clk);
      #1 rsp_ready = 1'b1;
      wait_idle();
      check("withdraw_idle", 32'(busy), 0);

      // Operand change right after grant.
      op_a = 4'b1000; op_b = 4'b1000;
      grant_wait(4'b1000, 1);
      op_a = '0; op_b = '0;
      wait_idle();

      // Reset during EXEC.
      grant_wait(4'hF, 0);
      rst_n = 1'b0;
      #1 outputs_zero("midreset");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      check("first_after_reset", 32'(gnt), 32'h1);
      req = '0;
      wait_idle();

      // Randomised traffic.
      for (int c = 0; c < 400; c++) begin
         @(posedge clk); #1;
         req       = N'($urandom);
         op_a      = (N*W)'($urandom);
         op_b      = (N*W)'($urandom);
         rsp_ready = ($urandom_range(0, 3) != 0);
      end
      req = '0; rsp_ready = 1'b1;
      wait_idle();
      repeat (2) @(posedge clk);
      check("sb_drained", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
